sha3_lane_gearbox: RTL and testbench

SHA3_LANE_GEARBOX -- requirements
Module: sha3_lane_gearbox

---
 rtl/sha3_lane_gearbox.sv | 137 +++++++++++++
 tb/tb_sha3_lane_gearbox.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_lane_gearbox.sv
// sha3_lane_gearbox: repacks 64-bit SHA-3 lanes into OUT_W-bit slices.
// The bit stream is held MSB-aligned in an accumulator; the final slice of a
// message carries any remainder bits, zero padding, and the spare field in the
// low SPARE_W bits. When the remainder and spare do not fit together, the
// spare gets a slice of its own.
module sha3_lane_gearbox #(
  parameter int OUT_W   = 48,
  parameter int SPARE_W = 16,
  localparam int SW1    = (SPARE_W > 0) ? SPARE_W : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ivalid,
  output logic             iready,
  input  logic [63:0]      ilane,
  input  logic             ilast,
  input  logic [SW1-1:0]   spare,
  output logic             ovalid,
  input  logic             oready,
  output logic [OUT_W-1:0] odata,
  output logic             olast
);

  localparam int ACC_W = 64 + OUT_W - 1;
  localparam int CW    = $clog2(OUT_W + 64);
  localparam logic [CW-1:0] OW_C    = CW'(OUT_W);
  localparam logic [CW-1:0] TAILMAX = CW'(OUT_W - SPARE_W);
  localparam logic [CW-1:0] LANE_C  = CW'(64);

  typedef enum logic [1:0] {ACCUM, DRAIN, TAIL, SPARE_ONLY} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW1-1:0]   spare_q, spare_d;

  logic [ACC_W-1:0] lane_ext;
  logic [OUT_W-1:0] top;
  logic [OUT_W-1:0] spare_ext;
  logic [CW-1:0]    cnt_sub;

  // Incoming lane placed at the top; shifted down by the current fill level.
  assign lane_ext = {ilane, {(OUT_W-1){1'b0}}};
  assign top      = acc_q[ACC_W-1 -: OUT_W];
  assign cnt_sub  = count_q - OW_C;

  generate
    if (SPARE_W > 0) begin : g_spare
      assign spare_ext = OUT_W'(spare_q);
    end else begin : g_nospare
      assign spare_ext = '0;
    end
  endgenerate

  // State, accumulator, fill count and captured spare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      spare_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      spare_q <= spare_d;
    end
  end

  // Next-state, handshakes and slice formatting.
  // Entering DRAIN always leaves count >= OUT_W (a lane is 64 >= OUT_W bits),
  // so the remainder branch is decided as each drain slice is taken and no
  // bubble cycle is needed.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    spare_d = spare_q;
    iready  = 1'b0;
    ovalid  = 1'b0;
    olast   = 1'b0;
    odata   = top;
    case (state_q)
      ACCUM: begin
        iready = !rst && (count_q < OW_C);
        ovalid = (count_q >= OW_C);
        if (iready && ivalid) begin
          acc_d   = acc_q | (lane_ext >> count_q);
          count_d = count_q + LANE_C;
          if (ilast) begin
            spare_d = spare;
            state_d = DRAIN;
          end
        end else if (ovalid && oready) begin
          acc_d   = acc_q << OUT_W;
          count_d = cnt_sub;
        end
      end
      DRAIN: begin
        ovalid = 1'b1;
        olast  = (SPARE_W == 0) && (count_q == OW_C);
        if (oready) begin
          acc_d   = acc_q << OUT_W;
          count_d = cnt_sub;
          if (cnt_sub >= OW_C)
            state_d = DRAIN;
          else if (cnt_sub == '0)
            state_d = (SPARE_W == 0) ? ACCUM : SPARE_ONLY;
          else
            state_d = TAIL;
        end
      end
      TAIL: begin
        ovalid = 1'b1;
        olast  = (count_q <= TAILMAX);
        odata  = olast ? (top | spare_ext) : top;
        if (oready) begin
          acc_d   = '0;
          count_d = '0;
          state_d = olast ? ACCUM : SPARE_ONLY;
        end
      end
      SPARE_ONLY: begin
        ovalid = 1'b1;
        olast  = 1'b1;
        odata  = spare_ext;
        if (oready) begin
          acc_d   = '0;
          count_d = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

endmodule

// File: tb/tb_sha3_lane_gearbox.sv
// Bench for sha3_lane_gearbox: three instances (OUT_W 48/64/24, SPARE_W 16)
// checked against a bit-stream model of the slicing rules.
module tb_sha3_lane_gearbox;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ivalid [3];
  logic        ilast  [3];
  logic        oready [3];
  logic        iready [3];
  logic        ovalid [3];
  logic        olast  [3];
  logic [63:0] ilane  [3];
  logic [15:0] spare  [3];
  logic [63:0] odata  [3];
  logic [47:0] od0;
  logic [63:0] od1;
  logic [23:0] od2;

  assign odata[0] = {16'h0, od0};
  assign odata[1] = od1;
  assign odata[2] = {40'h0, od2};

  sha3_lane_gearbox #(.OUT_W(48), .SPARE_W(16)) u0 (
    .clk(clk), .rst(rst), .ivalid(ivalid[0]), .iready(iready[0]), .ilane(ilane[0]),
    .ilast(ilast[0]), .spare(spare[0]), .ovalid(ovalid[0]), .oready(oready[0]),
    .odata(od0), .olast(olast[0]));
  sha3_lane_gearbox #(.OUT_W(64), .SPARE_W(16)) u1 (
    .clk(clk), .rst(rst), .ivalid(ivalid[1]), .iready(iready[1]), .ilane(ilane[1]),
    .ilast(ilast[1]), .spare(spare[1]), .ovalid(ovalid[1]), .oready(oready[1]),
    .odata(od1), .olast(olast[1]));
  sha3_lane_gearbox #(.OUT_W(24), .SPARE_W(16)) u2 (
    .clk(clk), .rst(rst), .ivalid(ivalid[2]), .iready(iready[2]), .ilane(ilane[2]),
    .ilast(ilast[2]), .spare(spare[2]), .ovalid(ovalid[2]), .oready(oready[2]),
    .odata(od2), .olast(olast[2]));

  int checks = 0;
  int failures = 0;
  bit stall_en = 1'b0;

  logic [64:0] eq0[$];
  logic [64:0] eq1[$];
  logic [64:0] eq2[$];
  logic [63:0] lanes[8];

  function automatic int ow_of(input int k);
    return (k == 0) ? 48 : (k == 1) ? 64 : 24;
  endfunction

  task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int k, input logic [64:0] v);
    case (k)
      0: eq0.push_back(v);
      1: eq1.push_back(v);
      default: eq2.push_back(v);
    endcase
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? eq0.size() : (k == 1) ? eq1.size() : eq2.size();
  endfunction

  task automatic pop_exp(input int k, output logic [64:0] v);
    case (k)
      0: v = eq0.pop_front();
      1: v = eq1.pop_front();
      default: v = eq2.pop_front();
    endcase
  endtask

  function automatic logic sbit(input int p);
    logic [63:0] l;
    l = lanes[p / 64];
    return l[63 - (p % 64)];
  endfunction

  // Stream model: chop 64*n bits into ow-wide slices; the remainder plus the
  // spare close the message (one slice if they fit, else two).
  task automatic model(input int k, input int n, input logic [15:0] sp, input bit full_msg);
    int ow, total, off, r;
    logic [63:0] s;
    ow = ow_of(k);
    total = 64 * n;
    off = 0;
    while (off + ow <= total) begin
      s = '0;
      for (int j = 0; j < ow; j++) s[ow-1-j] = sbit(off + j);
      push_exp(k, {1'b0, s});
      off += ow;
    end
    if (full_msg) begin
      r = total - off;
      if (r == 0) begin
        push_exp(k, {1'b1, 48'h0, sp});
      end else begin
        s = '0;
        for (int j = 0; j < r; j++) s[ow-1-j] = sbit(off + j);
        if (r <= ow - 16) push_exp(k, {1'b1, s | {48'h0, sp}});
        else begin
          push_exp(k, {1'b0, s});
          push_exp(k, {1'b1, 48'h0, sp});
        end
      end
    end
  endtask

  // Output side: randomised or always-ready consumer.
  initial begin
    for (int k = 0; k < 3; k++) oready[k] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) oready[k] = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every handshake against the model, hold during stalls,
  // and no cycle with both iready and ovalid.
  logic [64:0] prev [3];
  bit          stalled [3];
  always @(negedge clk) begin
    logic [64:0] e;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        stalled[k] = 1'b0;
      end else begin
        check($sformatf("rdy_vld_excl%0d", k), {65'h0, iready[k] & ovalid[k]}, 66'h0);
        if (stalled[k])
          check($sformatf("stall_hold%0d", k), {ovalid[k], olast[k], odata[k]}, {1'b1, prev[k]});
        if (ovalid[k] && oready[k]) begin
          stalled[k] = 1'b0;
          if (qsize(k) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_slice%0d actual=%h required=none", k, {olast[k], odata[k]});
          end else begin
            pop_exp(k, e);
            check($sformatf("slice%0d", k), {1'b0, olast[k], odata[k]}, {1'b0, e});
          end
        end else if (ovalid[k]) begin
          stalled[k] = 1'b1;
          prev[k] = {olast[k], odata[k]};
        end else begin
          stalled[k] = 1'b0;
        end
      end
    end
  end

  task automatic send(input int k, input int n, input logic [15:0] sp, input bit with_last);
    int t;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      ivalid[k] = 1'b1;
      ilane[k]  = lanes[i];
      ilast[k]  = with_last && (i == n - 1);
      spare[k]  = (i == n - 1) ? sp : 16'($urandom);
      t = 0;
      @(negedge clk);
      while (!iready[k] && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout%0d actual=stuck required=iready", k);
      end
      @(posedge clk);
      #1;
      ivalid[k] = 1'b0;
      ilast[k]  = 1'b1;              // junk while not valid
      ilane[k]  = 64'hDEAD_BEEF_DEAD_BEEF;
      spare[k]  = 16'h5A5A;
    end
  endtask

  task automatic wait_drain(input int k);
    int t;
    t = 0;
    while (qsize(k) != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (qsize(k) != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout%0d actual=%0d required=0", k, qsize(k));
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic reset_vals(input string nm);
    for (int k = 0; k < 3; k++)
      check($sformatf("%s%0d", nm, k), {iready[k], ovalid[k], olast[k], odata[k][62:0]}, 66'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      ivalid[k] = 1'b0; ilast[k] = 1'b0; ilane[k] = '0; spare[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    reset_vals("reset_state");
    check("reset_odata_msb", {63'h0, odata[0][63], odata[1][63], odata[2][63]}, 66'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("iready_after_rst%0d", k), {65'h0, iready[k]}, 66'h1);

    // One lane, OUT_W=48.
    lanes[0] = 64'h0123_4567_89AB_CDEF;
    model(0, 1, 16'hBEEF, 1'b1);
    check("pin_031_a", {1'b0, eq0[0]}, {2'b00, 64'h0000_0123_4567_89AB});
    check("pin_031_b", {1'b0, eq0[1]}, {2'b01, 64'h0000_CDEF_0000_BEEF});
    send(0, 1, 16'hBEEF, 1'b1);
    wait_drain(0);

    // Five lanes, OUT_W=48.
    lanes[0] = 64'h0000_1111_2222_3333;
    lanes[1] = 64'h8888_9999_AAAA_BBBB;
    lanes[2] = 64'hCCCC_DDDD_EEEE_FFFF;
    lanes[3] = 64'h1234_5678_9ABC_DEF0;
    lanes[4] = 64'h4444_5555_6666_7777;
    model(0, 5, 16'hBEEF, 1'b1);
    check("pin_032_count", {34'h0, 32'(eq0.size())}, 66'd7);
    check("pin_032_s2", {1'b0, eq0[1]}, {2'b00, 64'h0000_3333_8888_9999});
    check("pin_032_s3", {1'b0, eq0[2]}, {2'b00, 64'h0000_AAAA_BBBB_CCCC});
    check("pin_032_s7", {1'b0, eq0[6]}, {2'b01, 64'h0000_6666_7777_BEEF});
    send(0, 5, 16'hBEEF, 1'b1);
    wait_drain(0);

    // Same message under random output stalls.
    stall_en = 1'b1;
    model(0, 5, 16'h1357, 1'b1);
    send(0, 5, 16'h1357, 1'b1);
    wait_drain(0);
    stall_en = 1'b0;

    // Two lanes, OUT_W=64.
    lanes[0] = 64'hFEDC_BA98_7654_3210;
    lanes[1] = 64'h0F1E_2D3C_4B5A_6978;
    model(1, 2, 16'hBEEF, 1'b1);
    check("pin_033_a", {1'b0, eq1[0]}, {2'b00, 64'hFEDC_BA98_7654_3210});
    check("pin_033_c", {1'b0, eq1[2]}, {2'b01, 64'h0000_0000_0000_BEEF});
    send(1, 2, 16'hBEEF, 1'b1);
    wait_drain(1);

    // One lane, OUT_W=24.
    lanes[0] = 64'h0123_4567_89AB_CDEF;
    model(2, 1, 16'hBEEF, 1'b1);
    check("pin_034_a", {1'b0, eq2[0]}, {2'b00, 64'h0000_0000_0001_2345});
    check("pin_034_c", {1'b0, eq2[2]}, {2'b00, 64'h0000_0000_00CD_EF00});
    check("pin_034_d", {1'b0, eq2[3]}, {2'b01, 64'h0000_0000_0000_BEEF});
    send(2, 1, 16'hBEEF, 1'b1);
    wait_drain(2);

    // Three random lanes on the 64 and 24 instances with stalls.
    stall_en = 1'b1;
    for (int i = 0; i < 3; i++) lanes[i] = {$urandom, $urandom};
    model(1, 3, 16'hA5C3, 1'b1);
    send(1, 3, 16'hA5C3, 1'b1);
    wait_drain(1);
    model(2, 3, 16'h3C5A, 1'b1);
    send(2, 3, 16'h3C5A, 1'b1);
    wait_drain(2);
    stall_en = 1'b0;

    // Reset after two of five lanes; leftover bits must be discarded.
    lanes[0] = 64'h0000_1111_2222_3333;
    lanes[1] = 64'h8888_9999_AAAA_BBBB;
    model(0, 2, 16'h0, 1'b0);
    send(0, 2, 16'h7777, 1'b0);
    wait_drain(0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    reset_vals("midmsg_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    lanes[0] = 64'h0123_4567_89AB_CDEF;
    model(0, 1, 16'hBEEF, 1'b1);
    send(0, 1, 16'hBEEF, 1'b1);
    wait_drain(0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
